// File: rtl/spmv_pkg.sv
// spmv_pkg: shared types and helpers for the SpMV accumulate PE.
// Slot records are stored at fixed maximum widths so one struct type serves
// every parameterisation; the PE uses only the low IDX_W/ACC_W bits.
package spmv_pkg;

  localparam int MAX_IDX_W = 32;
  localparam int MAX_ACC_W = 64;

  typedef enum logic [1:0] {RUN, WAIT, DRAIN} pe_state_e;

  typedef struct packed {
    logic                        valid;
    logic [MAX_IDX_W-1:0]        row;
    logic signed [MAX_ACC_W-1:0] acc;   // sign-extended from ACC_W
    logic                        satf;  // sticky clamp flag
  } slot_t;

  // Width sanity: the accumulator must hold a full product and fit the slot record.
  function automatic bit widths_ok(input int data_w, input int acc_w, input int idx_w);
    return (acc_w >= 2*data_w) && (acc_w <= MAX_ACC_W) && (idx_w <= MAX_IDX_W);
  endfunction

  // Add two ACC_W-wide values held sign-extended in MAX_ACC_W bits.
  // Returns {clamped, result}; result is again sign-extended from w bits.
  // clamp=0 gives two's-complement wrap at w bits.
  function automatic logic [MAX_ACC_W:0] sat_add(input logic signed [MAX_ACC_W-1:0] a,
                                                 input logic signed [MAX_ACC_W-1:0] b,
                                                 input int w, input logic clamp);
    logic signed [MAX_ACC_W:0]   sum, hi, lo;
    logic signed [MAX_ACC_W-1:0] wr;
    int sh;
    sum = {a[MAX_ACC_W-1], a} + {b[MAX_ACC_W-1], b};
    hi  = ({{MAX_ACC_W{1'b0}}, 1'b1} << (w-1)) - 1;
    lo  = ~hi;
    sh  = MAX_ACC_W - w;
    wr  = sum[MAX_ACC_W-1:0];
    wr  = wr <<< sh;
    wr  = wr >>> sh;
    if (clamp && (sum > hi)) return {1'b1, hi[MAX_ACC_W-1:0]};
    if (clamp && (sum < lo)) return {1'b1, lo[MAX_ACC_W-1:0]};
    return {1'b0, wr};
  endfunction

endpackage

// File: rtl/spmv_slot_cam.sv
// spmv_slot_cam: parallel tag match over the accumulator slots.
// Produces hit/hit index for the incoming row, lowest free slot and full flag.
module spmv_slot_cam
  import spmv_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = 2
) (
  input  logic [NUM_SLOTS-1:0]                slot_vld,
  input  logic [NUM_SLOTS-1:0][MAX_IDX_W-1:0] slot_row,
  input  logic [MAX_IDX_W-1:0]                key,
  output logic                                hit,
  output logic [SW-1:0]                       hit_idx,
  output logic [SW-1:0]                       free_idx,
  output logic                                full
);

  logic [NUM_SLOTS-1:0] match;

  // Match vector plus priority encodes (lowest index wins) for hit and free slot.
  always_comb begin
    match    = '0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) match[i] = slot_vld[i] && (slot_row[i] == key);
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (match[i])     hit_idx  = SW'(i);
      if (!slot_vld[i]) free_idx = SW'(i);
    end
  end

  assign hit  = |match;
  assign full = &slot_vld;

endmodule

// File: rtl/spmv_acc_pe.sv
// spmv_acc_pe: sparse-row multiply-accumulate PE with NUM_SLOTS tagged row
// accumulators, eviction on slot pressure and flush-driven drain.
// Optional feature: define SPMV_PE_SATURATE_EN for saturating accumulation
// with a per-slot sticky sat flag; otherwise accumulation wraps and sat is 0.
module spmv_acc_pe
  import spmv_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  parameter int IDX_W     = 12,
  parameter int NUM_SLOTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_val,
  input  logic signed [DATA_W-1:0] in_vec,
  input  logic [IDX_W-1:0]         in_row,
  input  logic                     flush,
  output logic                     flush_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_row,
  output logic [ACC_W-1:0]         out_acc,
  output logic                     overlap,
  output logic                     sat,
  output logic                     busy
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int PW = 2*DATA_W;
`ifdef SPMV_PE_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  if (!widths_ok(DATA_W, ACC_W, IDX_W) || NUM_SLOTS < 2) begin : g_bad_cfg
    $error("spmv_acc_pe: unsupported parameter combination");
  end

  pe_state_e                   state;
  slot_t                       slots [NUM_SLOTS];
  logic                        m_vld;
  logic signed [PW-1:0]        m_prod;
  logic [IDX_W-1:0]            m_row;
  logic                        ev_pend;   // current output is an eviction victim
  logic [SW-1:0]               evict_ptr, dr_idx;

  logic [NUM_SLOTS-1:0]                slot_vld;
  logic [NUM_SLOTS-1:0][MAX_IDX_W-1:0] slot_row;
  logic                        hit, full, any_live, victim_req, stall_a, out_hs;
  logic [SW-1:0]               hit_idx, free_idx, live_idx;
  logic signed [MAX_ACC_W-1:0] prod_x;
  logic [MAX_ACC_W:0]          sum_r;
  slot_t                       new_slot, out_src;

  // Flatten slot tags for the CAM and find the lowest live slot for drain.
  always_comb begin
    live_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_vld[i] = slots[i].valid;
      slot_row[i] = slots[i].row;
    end
    for (int i = NUM_SLOTS-1; i >= 0; i--) if (slots[i].valid) live_idx = SW'(i);
  end

  spmv_slot_cam #(.NUM_SLOTS(NUM_SLOTS), .SW(SW)) u_cam (
    .slot_vld (slot_vld),
    .slot_row (slot_row),
    .key      (MAX_IDX_W'(m_row)),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .free_idx (free_idx),
    .full     (full)
  );

  assign any_live   = |slot_vld;
  assign prod_x     = MAX_ACC_W'(m_prod);
  assign sum_r      = sat_add(slots[hit_idx].acc, prod_x, ACC_W, SAT_EN);
  assign new_slot   = '{valid: 1'b1, row: MAX_IDX_W'(m_row), acc: prod_x, satf: 1'b0};
  assign victim_req = m_vld && !hit && full;
  // M may move only when A retires it; a full miss retires on the victim handshake.
  assign stall_a    = victim_req && !(ev_pend && out_ready);
  assign out_hs     = out_valid && out_ready;
  assign out_src    = victim_req ? slots[evict_ptr] : slots[live_idx];
  assign in_ready   = !reset && (state == RUN) && !flush && !stall_a;
  assign busy       = any_live || m_vld || (state != RUN);

  // Pipeline M/A, slot updates, output register and flush FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      m_vld      <= 1'b0;
      m_prod     <= '0;
      m_row      <= '0;
      ev_pend    <= 1'b0;
      evict_ptr  <= '0;
      dr_idx     <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_acc    <= '0;
      sat        <= 1'b0;
      overlap    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      overlap    <= 1'b0;
      flush_done <= 1'b0;

      if (!stall_a) begin
        m_vld <= in_valid && in_ready && (in_val != '0) && (in_vec != '0);
        if (in_valid && in_ready) begin
          m_prod <= PW'(in_val) * PW'(in_vec);
          m_row  <= in_row;
        end
      end

      if (m_vld && !stall_a) begin
        if (hit) begin
          slots[hit_idx].acc  <= sum_r[MAX_ACC_W-1:0];
          slots[hit_idx].satf <= slots[hit_idx].satf | sum_r[MAX_ACC_W];
          overlap             <= 1'b1;
        end else if (!full) begin
          slots[free_idx] <= new_slot;
        end else begin
          slots[evict_ptr] <= new_slot;
          evict_ptr <= (evict_ptr == SW'(NUM_SLOTS-1)) ? '0 : evict_ptr + 1'b1;
        end
      end

      if (out_hs) begin
        out_valid <= 1'b0;
        ev_pend   <= 1'b0;
        if (!ev_pend) slots[dr_idx] <= '0;
      end else if (!out_valid && (victim_req || (state == DRAIN && any_live))) begin
        out_valid <= 1'b1;
        out_row   <= out_src.row[IDX_W-1:0];
        out_acc   <= out_src.acc[ACC_W-1:0];
        sat       <= SAT_EN & out_src.satf;
        ev_pend   <= victim_req;
        dr_idx    <= live_idx;
      end

      case (state)
        RUN:     if (flush) state <= WAIT;
        WAIT:    if (!m_vld && !ev_pend) state <= DRAIN;
        DRAIN:   if (!any_live && !out_valid) begin
                   state      <= RUN;
                   flush_done <= 1'b1;
                 end
        default: state <= RUN;
      endcase
    end
  end

endmodule
